// File: rtl/branch_resolve_if.sv
// Handshake and result bundle between the decode stage and the branch resolve unit.
// The master side issues branch requests and the slave side resolves them.
interface branch_resolve_if #(
  parameter int WIDTH     = 32,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 kill;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           mode;
  logic [WIDTH-1:0]     rs_data;
  logic [WIDTH-1:0]     rt_data;
  logic                 rs_ready;
  logic                 rt_ready;
  logic [PC_WIDTH-1:0]  pc_plus4;
  logic [15:0]          offset;
  logic                 out_valid;
  logic                 taken;
  logic [PC_WIDTH-1:0]  target;
  logic                 illegal;
  logic                 flush;
  logic                 stall;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] taken_count;
  logic [CNT_WIDTH-1:0] stall_count;

  modport master (
    output kill, in_valid, mode, rs_data, rt_data, rs_ready, rt_ready, pc_plus4, offset,
    input  in_ready, out_valid, taken, target, illegal, flush, stall,
           branch_count, taken_count, stall_count
  );

  modport slave (
    input  kill, in_valid, mode, rs_data, rt_data, rs_ready, rt_ready, pc_plus4, offset,
    output in_ready, out_valid, taken, target, illegal, flush, stall,
           branch_count, taken_count, stall_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: waits for forwarded operands, evaluates the condition,
// computes the target and keeps saturating branch/taken/stall counters.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic              clock,
  input logic              reset,
  branch_resolve_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            mode_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [15:0]           off_q;
  logic                  taken_q, illegal_q;
  logic [PC_WIDTH-1:0]   target_q;
  logic [CNT_WIDTH-1:0]  branchCnt_q, takenCnt_q, stallCnt_q;

  logic                  inReady, accept, opsReady, resolveNow;
  logic [2:0]            effMode;
  logic [PC_WIDTH-1:0]   effPc;
  logic [15:0]           effOff;
  logic                  condTaken, condIllegal;
  logic [PC_WIDTH-1:0]   condTarget;
  logic                  rsNeg, rsZero;

  // A fresh accept evaluates the live request fields; a waiting branch uses the latched copy.
  always_comb begin
    inReady = ((state_q == IDLE) || (state_q == RESOLVE)) && !bus.kill;
    accept  = inReady && bus.in_valid;
    effMode = accept ? bus.mode     : mode_q;
    effPc   = accept ? bus.pc_plus4 : pc_q;
    effOff  = accept ? bus.offset   : off_q;
    opsReady = ((effMode > 3'd5) || bus.rs_ready) && ((effMode > 3'd1) || bus.rt_ready);
  end

  always_comb begin
    state_d    = state_q;
    resolveNow = 1'b0;
    case (state_q)
      IDLE, RESOLVE: begin
        state_d = IDLE;
        if (accept) begin
          state_d    = opsReady ? RESOLVE : WAIT_OPS;
          resolveNow = opsReady;
        end
      end
      WAIT_OPS: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (opsReady) begin
          state_d    = RESOLVE;
          resolveNow = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsNeg       = bus.rs_data[WIDTH-1];
    rsZero      = (bus.rs_data == '0);
    condIllegal = (effMode == 3'b111);
    condTarget  = effPc + {{(PC_WIDTH-18){effOff[15]}}, effOff, 2'b00};
    case (effMode)
      3'd0:    condTaken = (bus.rs_data == bus.rt_data);
      3'd1:    condTaken = (bus.rs_data != bus.rt_data);
      3'd2:    condTaken = rsNeg || rsZero;
      3'd3:    condTaken = !rsNeg && !rsZero;
      3'd4:    condTaken = rsNeg;
      3'd5:    condTaken = !rsNeg;
      3'd6:    condTaken = 1'b1;
      default: condTaken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= '0;
      pc_q      <= '0;
      off_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else begin
      if (accept) begin
        mode_q <= bus.mode;
        pc_q   <= bus.pc_plus4;
        off_q  <= bus.offset;
      end
      if (resolveNow) begin
        taken_q   <= condTaken;
        illegal_q <= condIllegal;
        target_q  <= condTarget;
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      branchCnt_q <= '0;
      takenCnt_q  <= '0;
      stallCnt_q  <= '0;
    end else begin
      if ((state_q == RESOLVE) && (branchCnt_q != '1))
        branchCnt_q <= branchCnt_q + 1'b1;
      if ((state_q == RESOLVE) && taken_q && (takenCnt_q != '1))
        takenCnt_q <= takenCnt_q + 1'b1;
      if ((state_q == WAIT_OPS) && (stallCnt_q != '1))
        stallCnt_q <= stallCnt_q + 1'b1;
    end
  end

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = (state_q == RESOLVE);
  assign bus.taken        = taken_q;
  assign bus.target       = target_q;
  assign bus.illegal      = illegal_q;
  assign bus.flush        = (state_q == RESOLVE) && taken_q;
  assign bus.stall        = (state_q == WAIT_OPS);
  assign bus.branch_count = branchCnt_q;
  assign bus.taken_count  = takenCnt_q;
  assign bus.stall_count  = stallCnt_q;

endmodule
